// File: rtl/sdram_port_arb.sv
// -----------------------------------------------------------------------------
// sdram_port_arb
//
// Shares one burst-oriented SDRAM command interface between two burst masters.
// A port is granted for an entire burst. When both ports want the bus, the
// port that did not win last time gets it (round-robin). Each read grant pushes
// a {port, size} tag into a small in-order FIFO. Returning read beats are then
// steered to the port named by the head tag.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   pN_address              burst start address (held by the master for the burst)
//   pN_writedata            write beat data
//   pN_read / pN_write      burst requests (write wins if both are set)
//   pN_burst_size           beats in burst (0 is treated as 1)
//   pN_byte_enable          byte enables
//   pN_rdy                  beat accepted this cycle (granted port only)
//   pN_readdata             returned read data (broadcast)
//   pN_readdatavalid        returned read beat belongs to port N
//   m_*                     command/data bus towards the SDRAM interface core
//   m_readdata/_valid       read return from the SDRAM interface core
//   m_rdy                   core accepts the current beat
//   err_orphan              sticky: read data returned with no read outstanding
// -----------------------------------------------------------------------------
module sdram_port_arb #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int BURST_W   = 9,
  parameter int TAG_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  // port 0
  input  logic [ADDR_W-1:0]  p0_address,
  input  logic [DATA_W-1:0]  p0_writedata,
  input  logic               p0_read,
  input  logic               p0_write,
  input  logic [BURST_W-1:0] p0_burst_size,
  input  logic [1:0]         p0_byte_enable,
  output logic               p0_rdy,
  output logic [DATA_W-1:0]  p0_readdata,
  output logic               p0_readdatavalid,
  // port 1
  input  logic [ADDR_W-1:0]  p1_address,
  input  logic [DATA_W-1:0]  p1_writedata,
  input  logic               p1_read,
  input  logic               p1_write,
  input  logic [BURST_W-1:0] p1_burst_size,
  input  logic [1:0]         p1_byte_enable,
  output logic               p1_rdy,
  output logic [DATA_W-1:0]  p1_readdata,
  output logic               p1_readdatavalid,
  // SDRAM interface side
  output logic [ADDR_W-1:0]  m_address,
  output logic [DATA_W-1:0]  m_writedata,
  output logic               m_read,
  output logic               m_write,
  output logic [BURST_W-1:0] m_burst_size,
  output logic [1:0]         m_byte_enable,
  input  logic [DATA_W-1:0]  m_readdata,
  input  logic               m_readdatavalid,
  input  logic               m_rdy,
  output logic               err_orphan
);

  localparam int TAG_AW = $clog2(TAG_DEPTH);
  localparam logic [BURST_W-1:0] BURST_ONE    = BURST_W'(1);
  localparam logic [TAG_AW-1:0]  TAG_PTR_ONE  = TAG_AW'(1);
  localparam logic [TAG_AW:0]    TAG_CNT_ONE  = (TAG_AW+1)'(1);
  localparam logic [TAG_AW:0]    TAG_CNT_FULL = (TAG_AW+1)'(TAG_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Per-port inputs gathered into arrays so the granted port can be indexed
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0]  w_addr_in  [2];
  logic [DATA_W-1:0]  w_wdata_in [2];
  logic [BURST_W-1:0] w_size_in  [2];
  logic [1:0]         w_be_in    [2];
  logic [1:0]         w_rd_in;
  logic [1:0]         w_wr_in;

  assign w_addr_in[0]  = p0_address;
  assign w_addr_in[1]  = p1_address;
  assign w_wdata_in[0] = p0_writedata;
  assign w_wdata_in[1] = p1_writedata;
  assign w_size_in[0]  = p0_burst_size;
  assign w_size_in[1]  = p1_burst_size;
  assign w_be_in[0]    = p0_byte_enable;
  assign w_be_in[1]    = p1_byte_enable;
  assign w_rd_in       = {p1_read,  p0_read};
  assign w_wr_in       = {p1_write, p0_write};

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_next;
  logic               r_gnt;
  logic               r_is_wr;
  logic [BURST_W-1:0] r_size;
  logic [BURST_W-1:0] r_cnt;
  logic               r_last_grant;

  // Tag FIFO
  logic               r_tag_port [TAG_DEPTH];
  logic [BURST_W-1:0] r_tag_size [TAG_DEPTH];
  logic [TAG_AW-1:0]  r_wr_ptr;
  logic [TAG_AW-1:0]  r_rd_ptr;
  logic [TAG_AW:0]    r_tag_count;
  logic [BURST_W-1:0] r_ret_cnt;
  logic               r_err_orphan;

  logic               w_tag_empty;
  logic               w_tag_full;
  logic               w_head_port;
  logic [BURST_W-1:0] w_head_size;
  logic               w_ret_beat;
  logic               w_pop;
  logic               w_push;

  // Grant decision
  logic [1:0]         w_req;
  logic               w_gnt_valid;
  logic               w_gnt_port;
  logic               w_gnt_wr;
  logic [BURST_W-1:0] w_gnt_size;
  logic               w_last_beat;

  logic [1:0]         w_rdy;
  logic [1:0]         w_rvalid;

  assign w_tag_empty = (r_tag_count == '0);
  assign w_tag_full  = (r_tag_count == TAG_CNT_FULL);
  assign w_head_port = r_tag_port[r_rd_ptr];
  assign w_head_size = r_tag_size[r_rd_ptr];

  // ---------------------------------------------------------------------------
  // Per-port request qualification and handshake decode.
  // A read only counts as a request while a tag slot is free, so a full FIFO
  // stalls reads without blocking writes.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign w_req[gi]    = w_wr_in[gi] | (w_rd_in[gi] & ~w_tag_full);
      assign w_rdy[gi]    = (r_state == S_XFER) && (r_gnt == 1'(gi)) && m_rdy;
      assign w_rvalid[gi] = w_ret_beat && (w_head_port == 1'(gi));
    end
  endgenerate

  assign p0_rdy           = w_rdy[0];
  assign p1_rdy           = w_rdy[1];
  assign p0_readdatavalid = w_rvalid[0];
  assign p1_readdatavalid = w_rvalid[1];
  assign p0_readdata      = m_readdata;
  assign p1_readdata      = m_readdata;
  assign err_orphan       = r_err_orphan;

  // Round-robin: on contention, the port that was not granted last wins
  always_comb begin
    w_gnt_port = 1'b0;
    if (w_req[0] && w_req[1]) begin
      w_gnt_port = ~r_last_grant;
    end else if (w_req[1]) begin
      w_gnt_port = 1'b1;
    end
  end

  assign w_gnt_valid = |w_req;
  // A port raising both read and write is serviced as a write
  assign w_gnt_wr    = w_wr_in[w_gnt_port];
  assign w_gnt_size  = (w_size_in[w_gnt_port] == '0) ? BURST_ONE : w_size_in[w_gnt_port];
  assign w_push      = (r_state == S_IDLE) && w_gnt_valid && !w_gnt_wr;
  assign w_last_beat = (r_state == S_XFER) && m_rdy && (r_cnt == r_size - BURST_ONE);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_gnt_valid) w_state_next = S_XFER;
      S_XFER: if (w_last_beat) w_state_next = S_DONE;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM: output decode. Only the granted port's address/data reach the bus,
  // and everything is forced to zero outside a transfer.
  always_comb begin
    m_address     = '0;
    m_writedata   = '0;
    m_read        = 1'b0;
    m_write       = 1'b0;
    m_burst_size  = '0;
    m_byte_enable = '0;
    if (r_state == S_XFER) begin
      m_write       = r_is_wr;
      m_read        = ~r_is_wr;
      m_address     = w_addr_in[r_gnt];
      m_writedata   = w_wdata_in[r_gnt];
      m_byte_enable = w_be_in[r_gnt];
      m_burst_size  = r_size;
    end
  end

  // ---------------------------------------------------------------------------
  // Burst bookkeeping: latched grant, command type, size and beat counter.
  // last_grant only moves at the end of a burst, so round-robin fairness is
  // per burst rather than per beat.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt        <= 1'b0;
      r_is_wr      <= 1'b0;
      r_size       <= '0;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
    end else begin
      if ((r_state == S_IDLE) && w_gnt_valid) begin
        r_gnt   <= w_gnt_port;
        r_is_wr <= w_gnt_wr;
        r_size  <= w_gnt_size;
        r_cnt   <= '0;
      end else if ((r_state == S_XFER) && m_rdy) begin
        if (w_last_beat) begin
          r_cnt        <= '0;
          r_last_grant <= r_gnt;
        end else begin
          r_cnt <= r_cnt + BURST_ONE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tag FIFO storage (payload needs no reset; validity is tracked by count)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_port[r_wr_ptr] <= w_gnt_port;
      r_tag_size[r_wr_ptr] <= w_gnt_size;
    end
  end

  // Return path: beats are only honoured while a tag is outstanding; the head
  // tag retires once its full burst has come back.
  assign w_ret_beat = m_readdatavalid && !w_tag_empty;
  assign w_pop      = w_ret_beat && (r_ret_cnt == w_head_size - BURST_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_tag_count  <= '0;
      r_ret_cnt    <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + TAG_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + TAG_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_tag_count <= r_tag_count + TAG_CNT_ONE;
        2'b01:   r_tag_count <= r_tag_count - TAG_CNT_ONE;
        default: r_tag_count <= r_tag_count;
      endcase
      if (w_ret_beat) begin
        r_ret_cnt <= w_pop ? '0 : (r_ret_cnt + BURST_ONE);
      end
      if (m_readdatavalid && w_tag_empty) begin
        r_err_orphan <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arb.sv
module tb_sdram_port_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] p0_address, p1_address;
  logic [15:0] p0_writedata, p1_writedata;
  logic        p0_read, p0_write, p1_read, p1_write;
  logic [8:0]  p0_burst_size, p1_burst_size;
  logic [1:0]  p0_byte_enable, p1_byte_enable;
  logic        p0_rdy, p1_rdy;
  logic [15:0] p0_readdata, p1_readdata;
  logic        p0_readdatavalid, p1_readdatavalid;
  logic [23:0] m_address;
  logic [15:0] m_writedata;
  logic        m_read, m_write;
  logic [8:0]  m_burst_size;
  logic [1:0]  m_byte_enable;
  logic [15:0] m_readdata;
  logic        m_readdatavalid;
  logic        m_rdy;
  logic        err_orphan;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          port;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];
  bit   ord_q[$];

  always #5 clk = ~clk;

  sdram_port_arb dut (
    .clk(clk), .rst_n(rst_n),
    .p0_address(p0_address), .p0_writedata(p0_writedata), .p0_read(p0_read),
    .p0_write(p0_write), .p0_burst_size(p0_burst_size), .p0_byte_enable(p0_byte_enable),
    .p0_rdy(p0_rdy), .p0_readdata(p0_readdata), .p0_readdatavalid(p0_readdatavalid),
    .p1_address(p1_address), .p1_writedata(p1_writedata), .p1_read(p1_read),
    .p1_write(p1_write), .p1_burst_size(p1_burst_size), .p1_byte_enable(p1_byte_enable),
    .p1_rdy(p1_rdy), .p1_readdata(p1_readdata), .p1_readdatavalid(p1_readdatavalid),
    .m_address(m_address), .m_writedata(m_writedata), .m_read(m_read), .m_write(m_write),
    .m_burst_size(m_burst_size), .m_byte_enable(m_byte_enable), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .m_rdy(m_rdy), .err_orphan(err_orphan)
  );

  // Advance to just after the next rising edge; inputs are driven from here
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    p0_address = '0; p1_address = '0; p0_writedata = '0; p1_writedata = '0;
    p0_read = 0; p0_write = 0; p1_read = 0; p1_write = 0;
    p0_burst_size = '0; p1_burst_size = '0; p0_byte_enable = '0; p1_byte_enable = '0;
    m_readdata = '0; m_readdatavalid = 0; m_rdy = 1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    p0_write = 1; p0_burst_size = 9'd4; p0_address = 24'h123456;
    m_readdatavalid = 1;
    repeat (2) cyc();
    @(negedge clk);
    total++;
    if ({m_read, m_write, p0_rdy, p1_rdy, p0_readdatavalid, p1_readdatavalid, err_orphan} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {m_read, m_write, p0_rdy, p1_rdy, p0_readdatavalid, p1_readdatavalid, err_orphan});
    end
    total++;
    if (m_address !== 24'h0 || m_burst_size !== 9'h0) begin
      bad++;
      $display("FAIL reset_bus: addr=%h size=%0d want 0/0", m_address, m_burst_size);
    end
    cyc();
    clear_inputs();
    rst_n = 1;
    @(negedge clk);
    total++;
    if (m_write !== 1'b0 || err_orphan !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: m_write=%b err=%b want 0/0", m_write, err_orphan);
    end
    cyc();
    $display("test_reset done");
  endtask

  task automatic test_single_write();
    int n0 = 0;
    int n1 = 0;
    bit exp_w;
    apply_reset();
    p0_write = 1; p0_burst_size = 9'd8; p0_address = 24'hA00010;
    p0_writedata = 16'h5A5A; p0_byte_enable = 2'b11;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) p0_write = 0;
      @(negedge clk);
      exp_w = (i >= 1 && i <= 8);
      total++;
      if (m_write !== exp_w) begin
        bad++;
        $display("FAIL single_m_write cyc%0d: got %b want %b", i, m_write, exp_w);
      end
      if (exp_w) begin
        total++;
        if (m_address !== 24'hA00010 || m_burst_size !== 9'd8 || m_writedata !== 16'h5A5A) begin
          bad++;
          $display("FAIL single_bus cyc%0d: addr=%h size=%0d data=%h", i, m_address, m_burst_size, m_writedata);
        end
      end
      if (p0_rdy === 1'b1) n0++;
      if (p1_rdy === 1'b1) n1++;
      cyc();
    end
    total++;
    if (n0 != 8 || n1 != 0) begin
      bad++;
      $display("FAIL single_rdy_count: p0=%0d p1=%0d want 8/0", n0, n1);
    end
    $display("test_single_write done: p0_rdy pulses=%0d", n0);
  endtask

  task automatic test_arbitration();
    bit prev_cmd = 0;
    bit cmd;
    bit exp_p;
    int last_cmd = -1;
    apply_reset();
    p0_write = 1; p0_burst_size = 9'd4; p0_address = 24'h000100;
    p1_read  = 1; p1_burst_size = 9'd4; p1_address = 24'h000200;
    ord_q = {};
    ord_q.push_back(0); ord_q.push_back(1); ord_q.push_back(0); ord_q.push_back(1);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      cmd = m_read | m_write;
      if (cmd && !prev_cmd) begin
        total++;
        if (ord_q.size() == 0) begin
          bad++;
          $display("FAIL arb_extra_burst cyc%0d: unexpected burst start", i);
        end else begin
          exp_p = ord_q.pop_front();
          if (p1_rdy !== exp_p || p0_rdy !== !exp_p || m_write !== !exp_p ||
              m_address !== (exp_p ? 24'h000200 : 24'h000100)) begin
            bad++;
            $display("FAIL arb_order cyc%0d: rdy1=%b rdy0=%b wr=%b addr=%h want port %0d",
                     i, p1_rdy, p0_rdy, m_write, m_address, exp_p);
          end
          $display("arb burst start cyc%0d port=%0d", i, exp_p);
        end
        if (last_cmd >= 0) begin
          total++;
          if (i - last_cmd - 1 != 2) begin
            bad++;
            $display("FAIL arb_gap cyc%0d: idle gap %0d want 2", i, i - last_cmd - 1);
          end
        end
      end
      if (cmd) last_cmd = i;
      prev_cmd = cmd;
      cyc();
    end
    p0_write = 0; p1_read = 0;
    total++;
    if (ord_q.size() != 0) begin
      bad++;
      $display("FAIL arb_missing: %0d bursts not seen want 0", ord_q.size());
    end
  endtask

  task automatic test_stall();
    logic [7:0] rdy_pat = 8'b1100_1001;
    int n0 = 0;
    bit exp_w;
    apply_reset();
    p0_write = 1; p0_burst_size = 9'd4; p0_address = 24'h0BEEF0;
    for (int i = 0; i < 11; i++) begin
      if (i == 1) p0_write = 0;
      m_rdy = (i >= 1 && i <= 8) ? rdy_pat[i-1] : 1'b1;
      p0_writedata = 16'(i);
      @(negedge clk);
      exp_w = (i >= 1 && i <= 8);
      total++;
      if (m_write !== exp_w) begin
        bad++;
        $display("FAIL stall_m_write cyc%0d: got %b want %b", i, m_write, exp_w);
      end
      if (exp_w) begin
        total++;
        if (m_address !== 24'h0BEEF0 || p0_rdy !== m_rdy || p1_rdy !== 1'b0) begin
          bad++;
          $display("FAIL stall_beat cyc%0d: addr=%h p0_rdy=%b p1_rdy=%b want addr 0beef0 rdy %b/0",
                   i, m_address, p0_rdy, p1_rdy, m_rdy);
        end
      end
      if (p0_rdy === 1'b1) n0++;
      cyc();
    end
    m_rdy = 1;
    total++;
    if (n0 != 4) begin
      bad++;
      $display("FAIL stall_rdy_count: got %0d want 4", n0);
    end
    $display("test_stall done: p0_rdy pulses=%0d", n0);
  endtask

  task automatic test_read_return();
    exp_t e;
    apply_reset();
    sb = {};
    p0_read = 1; p0_burst_size = 9'd4; p0_address = 24'h001000;
    for (int j = 1; j <= 4; j++) begin e.port = 0; e.data = 16'(j); sb.push_back(e); end
    cyc();
    p0_read = 0;
    repeat (7) cyc();
    p1_read = 1; p1_burst_size = 9'd2; p1_address = 24'h002000;
    for (int j = 5; j <= 6; j++) begin e.port = 1; e.data = 16'(j); sb.push_back(e); end
    cyc();
    p1_read = 0;
    repeat (5) cyc();
    for (int j = 1; j <= 7; j++) begin
      // one idle slot in the middle of the return stream
      m_readdatavalid = (j != 4);
      m_readdata = (j < 4) ? 16'(j) : 16'(j - 1);
      @(negedge clk);
      if (m_readdatavalid) begin
        e = sb.pop_front();
        total++;
        if (p0_readdatavalid !== !e.port || p1_readdatavalid !== e.port ||
            p0_readdata !== e.data || p1_readdata !== e.data) begin
          bad++;
          $display("FAIL ret_route data=%h: v0=%b v1=%b rd=%h want port %0d data %h",
                   m_readdata, p0_readdatavalid, p1_readdatavalid, p0_readdata, e.port, e.data);
        end
        $display("return beat data=%h port=%0d", e.data, e.port);
      end else begin
        total++;
        if (p0_readdatavalid !== 1'b0 || p1_readdatavalid !== 1'b0) begin
          bad++;
          $display("FAIL ret_idle: v0=%b v1=%b want 0/0", p0_readdatavalid, p1_readdatavalid);
        end
      end
      cyc();
    end
    m_readdatavalid = 0;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL ret_leftover: %0d beats not returned", sb.size());
    end
  endtask

  task automatic test_tag_full();
    bit prev_cmd = 0;
    bit cmd;
    bit found = 0;
    int rd_starts = 0;
    int wr_starts = 0;
    apply_reset();
    p0_read = 1; p0_burst_size = 9'd1; p0_address = 24'h003000;
    for (int i = 0; i < 30; i++) begin
      if (i == 15) begin p1_write = 1; p1_burst_size = 9'd2; p1_address = 24'h004000; end
      @(negedge clk);
      cmd = m_read | m_write;
      if (cmd && !prev_cmd) begin
        if (m_read) rd_starts++;
        if (m_write) begin
          wr_starts++;
          total++;
          if (p1_rdy !== 1'b1 || p0_rdy !== 1'b0) begin
            bad++;
            $display("FAIL full_write_grant: p1_rdy=%b p0_rdy=%b want 1/0", p1_rdy, p0_rdy);
          end
        end
      end
      prev_cmd = cmd;
      cyc();
      if (wr_starts > 0) p1_write = 0;
    end
    total++;
    if (rd_starts != 4 || wr_starts != 1) begin
      bad++;
      $display("FAIL full_block: reads=%0d writes=%0d want 4/1", rd_starts, wr_starts);
    end
    m_readdatavalid = 1; m_readdata = 16'h00A5;
    @(negedge clk);
    total++;
    if (p0_readdatavalid !== 1'b1 || p1_readdatavalid !== 1'b0) begin
      bad++;
      $display("FAIL full_return: v0=%b v1=%b want 1/0", p0_readdatavalid, p1_readdatavalid);
    end
    cyc();
    m_readdatavalid = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (m_read === 1'b1) found = 1;
      cyc();
    end
    p0_read = 0;
    total++;
    if (!found) begin
      bad++;
      $display("FAIL full_fifth_read: m_read never rose within 10 cycles want granted");
    end
    $display("test_tag_full done: reads=%0d writes=%0d fifth=%0d", rd_starts, wr_starts, found);
  endtask

  // Runs directly after test_read_return, so the tag FIFO must already be empty
  task automatic test_orphan_and_reset();
    @(negedge clk);
    total++;
    if (err_orphan !== 1'b0) begin
      bad++;
      $display("FAIL orphan_pre: err=%b want 0", err_orphan);
    end
    cyc();
    m_readdatavalid = 1; m_readdata = 16'hBEEF;
    @(negedge clk);
    total++;
    if (p0_readdatavalid !== 1'b0 || p1_readdatavalid !== 1'b0) begin
      bad++;
      $display("FAIL orphan_drop: v0=%b v1=%b want 0/0", p0_readdatavalid, p1_readdatavalid);
    end
    cyc();
    m_readdatavalid = 0;
    repeat (3) cyc();
    @(negedge clk);
    total++;
    if (err_orphan !== 1'b1) begin
      bad++;
      $display("FAIL orphan_sticky: err=%b want 1", err_orphan);
    end
    cyc();
    p0_write = 1; p0_burst_size = 9'd8; p0_address = 24'h005000;
    cyc();
    p0_write = 0;
    repeat (2) cyc();
    @(negedge clk);
    total++;
    if (m_write !== 1'b1) begin
      bad++;
      $display("FAIL midreset_pre: m_write=%b want 1", m_write);
    end
    #2;
    rst_n = 0;
    #1;
    total++;
    if (m_write !== 1'b0 || err_orphan !== 1'b0 || p0_rdy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_abort: m_write=%b err=%b p0_rdy=%b want 0/0/0", m_write, err_orphan, p0_rdy);
    end
    cyc();
    rst_n = 1;
    cyc();
    $display("test_orphan_and_reset done");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_arbitration();
    test_stall();
    test_tag_full();
    test_read_return();
    test_orphan_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
